sha1_wsched: RTL
================

// Module: sha1_wsched
// PURPOSE
//  - SHA-1 message-schedule generator. It accepts one 512-bit padded message block.
//  - It emits the 80 schedule words W[0..79] as a stream with a valid/ready handshake.
//  - It sits between the block padder and the round datapath; the round datapath consumes
//    W[t] once per round index t.
//  - Storage is a 16-word sliding window, so no 80-word memory is needed.
// PARAMETERS
//  - NROUNDS  default 80  number of words emitted per block; legal range 17..255
//  - TW       default 8   width of the w_t index output
// PORTS
//  - clk        in   1    clock, rising edge
//  - rst        in   1    synchronous reset, active-high
//  - blk_valid  in   1    blk_data holds a padded block
//  - blk_ready  out  1    block accepted on blk_valid && blk_ready
//  - blk_data   in   512  block; word0 = [511:480], word15 = [31:0]
//  - w_valid    out  1    w_data/w_t/w_last are valid
//  - w_ready    in   1    consumer takes the word on w_valid && w_ready
//  - w_data     out  32   schedule word W[w_t]
//  - w_t        out  TW   round index 0..NROUNDS-1
//  - w_last     out  1    high with w_valid when w_t == NROUNDS-1
//  - busy       out  1    high while in RUN (block loaded, words pending)
// BEHAVIOUR
//  - Reset: one cycle of rst=1 at a clock edge forces the following.
//    - state = IDLE, window = 0, t = 0
//    - w_valid = 0, w_last = 0, w_data = 0, w_t = 0, busy = 0
//    - blk_ready = 1 from the first cycle after rst deasserts
//  - Reset applied mid-block aborts the block. Remaining words are never emitted, and no
//    w_last is produced.
//  - FSM states: IDLE, RUN.
//    - IDLE: blk_ready = 1, w_valid = 0.
//      - On blk_valid: window[i] <= word i (i = 0..15), t <= 0, go to RUN.
//    - RUN: blk_ready = 0, w_valid = 1, w_data = window[0], w_t = t.
//      - On w_ready: shift window[i] <= window[i+1]; window[15] <= nxt; t <= t+1.
//      - On w_ready when t == NROUNDS-1: go to IDLE, t <= 0.
//  - Next-word rule: nxt = rotl1(window[13] ^ window[8] ^ window[2] ^ window[0]).
//    - This equals W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]).
//    - All arithmetic is 32-bit XOR/rotate; no carries.
//  - Latency:
//    - Block accepted at edge N -> w_valid with w_t = 0 in the cycle after edge N.
//    - 80 words take at least 80 cycles.
//    - Minimum block-to-block period is 81 cycles: a new block is accepted the cycle after
//      the last word's handshake.
//  - Backpressure: while w_valid && !w_ready, w_data, w_t and w_last hold stable and the
//    window does not move. There is no limit on stall length.
//  - Simultaneous events:
//    - blk_valid during RUN is ignored because blk_ready = 0. Upstream must hold it.
//    - Last-word handshake and blk_valid in the same cycle: the block is NOT accepted that
//      cycle. It is accepted in the next IDLE cycle.
//  - Outputs are driven only from registers or from state; no combinational path from
//    inputs to outputs.
//  - t never wraps past NROUNDS-1. The RUN -> IDLE transition occurs exactly at t == NROUNDS-1.
// CONFIGURATION
//  - Macro SHA1_WSCHED_BSWAP_EN.
//    - Defined: each 32-bit input word is byte-swapped on load
//      ({b0,b1,b2,b3} -> {b3,b2,b1,b0}). This supports little-endian packed upstream.
//    - Undefined: words are loaded as-is, big-endian per FIPS 180-4.
//  - The output side and all timing are identical in both builds.
// TESTING
//  - "abc" block, no stalls: words 0x61626380, 14x0, 0x00000018.
//    - Expected: W0 = 0x61626380, W15 = 0x00000018, W16 = 0xC2C4C700, W17 = 0x00000000.
//    - Expected: W18 = 0x00000030, W19 = 0x85898E01.
//    - w_last only at w_t = 79.
//  - Backpressure: same block, w_ready low for 5 cycles at w_t = 20 and toggled every
//    cycle afterwards.
//    - Expected: the word sequence is identical to the no-stall run, and outputs are stable
//      while stalled.
//  - Back-to-back blocks: blk_valid held high with two blocks.
//    - Expected: second accept occurs exactly 1 cycle after the last-word handshake of
//      block 1, and its w_t restarts at 0.
//  - Reset mid-block: assert rst for 1 cycle at w_t = 37.
//    - Expected: the next cycle shows w_valid = 0 and blk_ready = 1.
//    - Expected: a new "abc" block then yields W16 = 0xC2C4C700.
//  - blk_valid during RUN with different data.
//    - Expected: ignored; the output stream matches the first block only.
//  - Build with SHA1_WSCHED_BSWAP_EN, word0 input 0x80636261.
//    - Expected: W0 = 0x61626380, and the remaining stream equals the "abc" vector.

Source files
------------

// File: rtl/sha1_wsched.sv
// SHA-1 message-schedule generator: loads one 512-bit block, streams W[0..NROUNDS-1].
// Build option: define SHA1_WSCHED_BSWAP_EN to byte-swap each input word on load.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   blk_valid/blk_ready  block handshake; blk_data word0 = [511:480], word15 = [31:0]
//   w_valid/w_ready      schedule-word handshake
//   w_data               schedule word W[w_t]
//   w_t                  round index 0..NROUNDS-1
//   w_last               flags the final word of the block
//   busy                 high while words of a loaded block are pending
//
// A 16-word sliding window holds W[t..t+15]. Each accepted word shifts the window
// and appends W[t+16], so no 80-word store is needed. All outputs come straight
// from flops, so there is no combinational path from any input to any output.

module sha1_wsched #(
    parameter int NROUNDS = 80,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic [511:0]  blk_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [31:0]   w_data,
    output logic [TW-1:0] w_t,
    output logic          w_last,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [TW-1:0] T_LAST = TW'(NROUNDS - 1);

    state_t        state_q, state_d;
    logic [31:0]   win_q [16];
    logic [31:0]   win_d [16];
    logic [TW-1:0] t_q, t_d;
    logic          w_last_q, w_last_d;
    logic [31:0]   mix;
    logic [31:0]   nxt;

    // Input word as it enters the window.
    function automatic logic [31:0] load_word(input logic [31:0] w);
`ifdef SHA1_WSCHED_BSWAP_EN
        // Upstream packs little-endian; restore FIPS 180-4 byte order.
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t])
    always_comb begin
        mix = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
        nxt = {mix[30:0], mix[31]};
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = load_word(blk_data[511-32*i -: 32]);
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = nxt;
                    if (t_q == T_LAST) begin
                        // Final word taken; a new block can enter next cycle.
                        t_d     = '0;
                        state_d = IDLE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so w_last is a plain flop output aligned with w_t.
        w_last_d = (state_d == RUN) && (t_d == T_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            w_last_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            w_last_q <= w_last_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign w_data    = win_q[0];
    assign w_t       = t_q;
    assign w_last    = w_last_q;

endmodule
